mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS core: sequences each instruction through fetch, decode, execute, memory and write-back states and drives the 5-bit ALUOp and datapath select/enable lines consumed by the datapath ALU. It sits between the instruction register, the ALU zero flag and a single-ported, ready-handshaked memory. It is the producer side of the ALUOp interface.

---
 rtl/mc_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: steps each instruction through its states and
// decodes the state register plus IR into ALUOp and datapath select/enable lines.
module mc_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic [4:0]            ALUOp,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            pc_src,
  output logic [1:0]            reg_dst,
  output logic [1:0]            wb_src,
  output logic                  illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_LD, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [4:0] ALU_NOP  = 5'h00, ALU_ADDU = 5'h01, ALU_ADD  = 5'h02,
                         ALU_SUBU = 5'h03, ALU_SUB  = 5'h04, ALU_AND  = 5'h05,
                         ALU_OR   = 5'h06, ALU_NOR  = 5'h07, ALU_XOR  = 5'h08,
                         ALU_SLT  = 5'h09, ALU_SLTU = 5'h0A, ALU_SLL  = 5'h11,
                         ALU_SRL  = 5'h12, ALU_SRA  = 5'h13, ALU_LUI  = 5'h14;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [5:0] opcode, funct;
  logic [4:0] r_aluop, i_aluop;
  logic       r_legal;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  always_comb begin
    r_aluop = ALU_NOP;
    r_legal = 1'b1;
    case (funct)
      6'h20:   r_aluop = ALU_ADD;
      6'h21:   r_aluop = ALU_ADDU;
      6'h22:   r_aluop = ALU_SUB;
      6'h23:   r_aluop = ALU_SUBU;
      6'h24:   r_aluop = ALU_AND;
      6'h25:   r_aluop = ALU_OR;
      6'h26:   r_aluop = ALU_XOR;
      6'h27:   r_aluop = ALU_NOR;
      6'h2A:   r_aluop = ALU_SLT;
      6'h2B:   r_aluop = ALU_SLTU;
      6'h00:   r_aluop = ALU_SLL;
      6'h02:   r_aluop = ALU_SRL;
      6'h03:   r_aluop = ALU_SRA;
      default: r_legal = 1'b0;
    endcase
  end

  // The datapath picks zero- vs sign-extension of the immediate from ALUOp.
  always_comb begin
    i_aluop = ALU_NOP;
    case (opcode)
      6'h08:   i_aluop = ALU_ADD;
      6'h09:   i_aluop = ALU_ADDU;
      6'h0A:   i_aluop = ALU_SLT;
      6'h0B:   i_aluop = ALU_SLTU;
      6'h0C:   i_aluop = ALU_AND;
      6'h0D:   i_aluop = ALU_OR;
      6'h0E:   i_aluop = ALU_XOR;
      6'h0F:   i_aluop = ALU_LUI;
      default: i_aluop = ALU_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ALUOp     = ALU_NOP;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_src    = 2'd0;
    reg_dst   = 2'd0;
    wb_src    = 2'd0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUOp     = ALU_ADDU;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        ALUOp     = ALU_ADDU;
        alu_src_b = 2'd3;
        case (opcode)
          6'h00:                      state_d = r_legal ? EXEC_R : HALT;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = EXEC_I;
          6'h23, 6'h2B:               state_d = MEM_ADDR;
          6'h04, 6'h05:               state_d = BRANCH;
          6'h02, 6'h03:               state_d = JUMP;
          default:                    state_d = HALT;
        endcase
      end
      EXEC_R: begin
        ALUOp     = r_aluop;
        alu_src_a = 1'b1;
        state_d   = WB_R;
      end
      EXEC_I: begin
        ALUOp     = i_aluop;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = WB_I;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        state_d   = FETCH;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        ALUOp     = ALU_ADDU;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = WB_LD;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      WB_LD: begin
        reg_write = 1'b1;
        wb_src    = 2'd1;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUOp     = ALU_SUBU;
        alu_src_a = 1'b1;
        pc_src    = 2'd1;
        pc_write  = (opcode == 6'h04) ? zero : !zero;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        if (opcode == 6'h03) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_src    = 2'd2;
        end
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Sticky: set on the same edge that enters HALT, so it reads 1 throughout HALT.
  assign illegal_d = illegal_q | (state_d == HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected output vectors are queued
// as stimulus is built and popped/compared at each negative clock edge.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [4:0]  ALUOp;
  logic        alu_src_a, mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_b, pc_src, reg_dst, wb_src;
  logic [20:0] obs;

  int checks = 0;
  int errors = 0;

  logic        mr_q[$];
  logic        z_q[$];
  logic [20:0] exp_q[$];
  string       tag_q[$];

  // Vector layout: {ALUOp, src_a, src_b, req, we, iord, irw, pcw, rw, pc_src, reg_dst, wb_src, illegal}
  localparam logic [20:0] F_WAIT = {5'h01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] F_RDY  = {5'h01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] DEC    = {5'h01, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] MADDR  = {5'h01, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] MRD    = {5'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] MWR    = {5'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] WBR    = {5'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0};
  localparam logic [20:0] WBI    = {5'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [20:0] WBLD   = {5'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0};
  localparam logic [20:0] HALTV  = {5'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1};
  localparam logic [20:0] JALV   = {5'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0};

  mc_ctrl #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .reg_dst(reg_dst), .wb_src(wb_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ALUOp, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_write, pc_write,
                reg_write, pc_src, reg_dst, wb_src, illegal};

  function automatic logic [20:0] exec_vec(input logic [4:0] op, input logic [1:0] sb);
    return {op, 1'b1, sb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
  endfunction

  function automatic logic [20:0] br_vec(input logic pcw);
    return {5'h03, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0};
  endfunction

  task automatic add(input logic mr, input logic z, input logic [20:0] e, input string t);
    mr_q.push_back(mr);
    z_q.push_back(z);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== F_WAIT) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h want %h", obs, F_WAIT);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (obs !== F_WAIT) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h want %h", obs, F_WAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [20:0] e;
    instr = 32'h00221821;
    add(1'b0, 1'b0, F_WAIT, "addu_fetch_wait");
    add(1'b1, 1'b0, F_RDY, "addu_fetch");
    add(1'b1, 1'b0, DEC, "addu_decode");
    add(1'b1, 1'b0, exec_vec(5'h01, 2'd0), "addu_exec");
    add(1'b1, 1'b0, WBR, "addu_wb");
    add(1'b0, 1'b0, F_WAIT, "addu_back_fetch");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [20:0] e;
    instr = 32'h8C220004;
    add(1'b1, 1'b0, F_RDY, "lw_fetch");
    add(1'b1, 1'b0, DEC, "lw_decode");
    add(1'b1, 1'b0, MADDR, "lw_addr");
    add(1'b0, 1'b0, MRD, "lw_rd_wait1");
    add(1'b0, 1'b0, MRD, "lw_rd_wait2");
    add(1'b1, 1'b0, MRD, "lw_rd_done");
    add(1'b1, 1'b0, WBLD, "lw_wb");
    add(1'b0, 1'b0, F_WAIT, "lw_back_fetch");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    logic [31:0] br_instr [4] = '{32'h10220003, 32'h10220003, 32'h14220003, 32'h14220003};
    logic        br_zero  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        br_take  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      instr = br_instr[i];
      add(1'b1, br_zero[i], F_RDY, "br_fetch");
      add(1'b1, br_zero[i], DEC, "br_decode");
      add(1'b1, br_zero[i], br_vec(br_take[i]), "br_exec");
      add(1'b0, br_zero[i], F_WAIT, "br_back_fetch");
      while (mr_q.size() > 0) begin
        mem_ready = mr_q.pop_front();
        zero = z_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL %s case %0d: got %h want %h", tag_q[0], i, obs, e);
        end
        void'(tag_q.pop_front());
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    logic [20:0] e;
    logic [31:0] it_instr [3] = '{32'h3422FFFF, 32'h3C021234, 32'h2022FFFF};
    logic [4:0]  it_op    [3] = '{5'h06, 5'h14, 5'h02};
    for (int i = 0; i < 3; i++) begin
      instr = it_instr[i];
      add(1'b1, 1'b0, F_RDY, "i_fetch");
      add(1'b1, 1'b0, DEC, "i_decode");
      add(1'b1, 1'b0, exec_vec(it_op[i], 2'd2), "i_exec");
      add(1'b1, 1'b0, WBI, "i_wb");
      add(1'b0, 1'b0, F_WAIT, "i_back_fetch");
      while (mr_q.size() > 0) begin
        mem_ready = mr_q.pop_front();
        zero = z_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL %s case %0d: got %h want %h", tag_q[0], i, obs, e);
        end
        void'(tag_q.pop_front());
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    instr = 32'h0C000010;
    add(1'b1, 1'b0, F_RDY, "jal_fetch");
    add(1'b1, 1'b0, DEC, "jal_decode");
    add(1'b1, 1'b0, JALV, "jal_jump");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
    instr = 32'h00432024;
    add(1'b1, 1'b0, F_RDY, "and_fetch");
    add(1'b1, 1'b0, DEC, "and_decode");
    add(1'b1, 1'b0, exec_vec(5'h05, 2'd0), "and_exec");
    add(1'b1, 1'b0, WBR, "and_wb");
    add(1'b0, 1'b0, F_WAIT, "and_back_fetch");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [20:0] e;
    logic [31:0] bad_instr [2] = '{32'hFC000000, 32'h0000003F};
    for (int i = 0; i < 2; i++) begin
      instr = bad_instr[i];
      add(1'b1, 1'b0, F_RDY, "halt_fetch");
      add(1'b1, 1'b0, DEC, "halt_decode");
      for (int k = 0; k < 12; k++) add(k[0], 1'b0, HALTV, "halt_hold");
      while (mr_q.size() > 0) begin
        mem_ready = mr_q.pop_front();
        zero = z_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL %s case %0d: got %h want %h", tag_q[0], i, obs, e);
        end
        void'(tag_q.pop_front());
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== F_WAIT) begin
        errors++;
        $display("[TB] FAIL halt_reset_clear case %0d: got %h want %h", i, obs, F_WAIT);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [20:0] e;
    instr = 32'hAC220004;
    add(1'b1, 1'b0, F_RDY, "sw_fetch");
    add(1'b1, 1'b0, DEC, "sw_decode");
    add(1'b1, 1'b0, MADDR, "sw_addr");
    add(1'b0, 1'b0, MWR, "sw_wait1");
    add(1'b0, 1'b0, MWR, "sw_wait2");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== F_WAIT) begin
      errors++;
      $display("[TB] FAIL sw_async_abort: got %h want %h", obs, F_WAIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    add(1'b1, 1'b0, F_RDY, "sw_after_reset_fetch");
    add(1'b1, 1'b0, DEC, "sw_after_reset_decode");
    add(1'b1, 1'b0, MADDR, "sw_after_reset_addr");
    add(1'b1, 1'b0, MWR, "sw_after_reset_wr");
    add(1'b0, 1'b0, F_WAIT, "sw_back_fetch");
    while (mr_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      zero = z_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h want %h", tag_q[0], obs, e);
      end
      void'(tag_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_itype();
    test_back_to_back();
    test_halt();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
